// File: rtl/ipg_reply_arbiter_pkg.sv
// Shared types and defaults for the IPG reply injection arbiter.
package ipg_pkg;

    // Default chunk width; matches the TX PHY datapath.
    localparam int DATA_WIDTH = 64;

    // IDLE: no grant held (one-cycle bubble between messages).
    // STREAM: one source owns the injection path until its message ends.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ipg_reply_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index found when
// scanning ptr, ptr+1, ... wrapping at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);

    // Scan from the far end back to ptr so the nearest requester is written last and wins.
    always_comb begin
        int j;
        grant_o = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_i[j[IDX_W-1:0]]) begin
                grant_o = j[IDX_W-1:0];
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ipg_reply_arbiter.sv
// Arbitrates NUM_REQ reply sources onto the single ipg_tx chunk write path.
// Grants are per message (held to the last beat), round-robin between
// messages, with a beat-count cap and an idle-source watchdog.
module ipg_reply_arbiter
    import ipg_pkg::*;
#(
    parameter int DATA_WIDTH = ipg_pkg::DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1,
    parameter int MAX_BEATS  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          memq_ready,
    output logic [DATA_WIDTH-1:0]         ipg_reply_chunk,
    output logic                          memq_write,
    output logic [IDX_W-1:0]              ipg_reply_src,
    output logic                          busy,
    output logic                          trunc_err,
    output logic                          timeout_err
);

    localparam int BEAT_W  = $clog2(MAX_BEATS + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    arb_state_t                           state_q, state_d;
    logic [IDX_W-1:0]                     grant_q, grant_d;
    logic [IDX_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]                    beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]                   stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-1:0]                chunk_q, chunk_d;
    logic [IDX_W-1:0]                     src_q, src_d;
    logic                                 write_q, write_d;
    logic                                 trunc_q, trunc_d;
    logic                                 tmo_q, tmo_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   src_data;
    logic [IDX_W-1:0]                     pick_idx;
    logic                                 pick_any;
    logic                                 g_valid;
    logic                                 g_last;
    logic                                 beat;
    logic [IDX_W-1:0]                     next_ptr;

    // Flat bus viewed as one data word per source.
    assign src_data = req_data;

    assign g_valid  = req_valid[grant_q];
    assign g_last   = req_last[grant_q];
    assign beat     = (state_q == STREAM) && g_valid && memq_ready;
    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    assign busy            = (state_q == STREAM);
    assign ipg_reply_chunk = chunk_q;
    assign ipg_reply_src   = src_q;
    assign memq_write      = write_q;
    assign trunc_err       = trunc_q;
    assign timeout_err     = tmo_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // Only the granted source sees ready, and only while the queue has room.
    always_comb begin
        req_ready = '0;
        if (state_q == STREAM) begin
            req_ready[grant_q] = memq_ready;
        end
    end

    // Next-state, counters and the registered chunk path.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        chunk_d     = chunk_q;
        src_d       = src_q;
        write_d     = 1'b0;
        trunc_d     = 1'b0;
        tmo_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                beat_cnt_d  = '0;
                stall_cnt_d = '0;
                if (enable && pick_any) begin
                    grant_d = pick_idx;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat) begin
                    write_d     = 1'b1;
                    chunk_d     = src_data[grant_q];
                    src_d       = grant_q;
                    stall_cnt_d = '0;
                    beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
                    // last takes priority: a last beat at the cap is a clean end
                    if (g_last || beat_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
                        trunc_d     = !g_last;
                        state_d     = IDLE;
                        rr_ptr_d    = next_ptr;
                        beat_cnt_d  = '0;
                    end
                end else if (memq_ready && !g_valid) begin
                    // downstream has room but the source is silent: a real stall
                    if (stall_cnt_q == STALL_W'(TIMEOUT - 1)) begin
                        tmo_d       = 1'b1;
                        state_d     = IDLE;
                        rr_ptr_d    = next_ptr;
                        beat_cnt_d  = '0;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbitration state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output register toward ipg_tx: fixed one-cycle accept-to-write latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_q <= '0;
            src_q   <= '0;
            write_q <= 1'b0;
            trunc_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            chunk_q <= chunk_d;
            src_q   <= src_d;
            write_q <= write_d;
            trunc_q <= trunc_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_ipg_reply_arbiter.sv
// Scoreboard bench for ipg_reply_arbiter: sources are modelled as beat queues,
// every accepted beat pushes its expected chunk, writes pop and compare.
module tb_ipg_reply_arbiter;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int MB = 16;
    localparam int TO = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      req_ready;
    logic               memq_ready;
    logic [DW-1:0]      ipg_reply_chunk;
    logic               memq_write;
    logic [IW-1:0]      ipg_reply_src;
    logic               busy;
    logic               trunc_err;
    logic               timeout_err;

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [DW-1:0] data; logic [IW-1:0] src; logic trunc; } exp_t;

    beat_t          srcq[NR][$];
    exp_t           sb[$];
    int             obs_src[$];
    int             obs_cyc[$];
    logic [NR-1:0]  vld_en;
    logic [NR-1:0]  acc;
    int             cnt_m[NR];
    int             cyc_n, n_checks, n_fail, n_tmo, n_trunc, n_wr, n_busy;

    always #5 clk = ~clk;

    ipg_reply_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .IDX_W      (IW),
        .MAX_BEATS  (MB),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .memq_ready      (memq_ready),
        .ipg_reply_chunk (ipg_reply_chunk),
        .memq_write      (memq_write),
        .ipg_reply_src   (ipg_reply_src),
        .busy            (busy),
        .trunc_err       (trunc_err),
        .timeout_err     (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            if (srcq[i].size() > 0) begin
                req_valid[i]          = vld_en[i];
                req_data[i*DW +: DW]  = srcq[i][0].data;
                req_last[i]           = srcq[i][0].last;
            end
        end
    endtask

    task automatic push_msg(input int s, input int n, input logic [63:0] base, input bit last_end);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 64'(k);
            b.last = last_end && (k == n - 1);
            srcq[s].push_back(b);
        end
    endtask

    // One clock: drive at negedge, log handshakes before posedge, check outputs at next negedge.
    task automatic cyc();
        exp_t e;
        drive();
        #1;
        acc = req_valid & req_ready;
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                cnt_m[i]++;
                e.data = srcq[i][0].data;
                e.src  = IW'(i);
                if (srcq[i][0].last) begin
                    e.trunc  = 1'b0;
                    cnt_m[i] = 0;
                end else if (cnt_m[i] == MB) begin
                    e.trunc  = 1'b1;
                    cnt_m[i] = 0;
                end else begin
                    e.trunc  = 1'b0;
                end
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) void'(srcq[i].pop_front());
        end
        chk("wr_latency", 64'(memq_write), 64'(|acc));
        if (busy) n_busy++;
        if (timeout_err) n_tmo++;
        if (trunc_err) n_trunc++;
        if (memq_write) begin
            n_wr++;
            obs_src.push_back(int'(ipg_reply_src));
            obs_cyc.push_back(cyc_n);
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("chunk", ipg_reply_chunk, e.data);
                chk("src", 64'(ipg_reply_src), 64'(e.src));
                chk("trunc", 64'(trunc_err), 64'(e.trunc));
            end
        end else begin
            chk("trunc_no_wr", 64'(trunc_err), 64'd0);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wait_wr(input int n, input int lim);
        for (int k = 0; k < lim; k++) begin
            if (n_wr >= n) break;
            cyc();
        end
        chk("wait_wr", 64'(n_wr), 64'(n));
    endtask

    task automatic flush();
        sb.delete();
        obs_src.delete();
        obs_cyc.delete();
        for (int i = 0; i < NR; i++) begin
            srcq[i].delete();
            cnt_m[i] = 0;
        end
        vld_en     = '1;
        memq_ready = 1'b1;
        n_tmo = 0; n_trunc = 0; n_wr = 0; n_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        drive();
        repeat (2) @(negedge clk);
        chk("rst_write", 64'(memq_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chunk", ipg_reply_chunk, 64'd0);
        chk("rst_src", 64'(ipg_reply_src), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_errs", 64'({trunc_err, timeout_err}), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        n_checks = 0; n_fail = 0; cyc_n = 0;
        enable = 1'b0;
        acc    = '0;
        @(negedge clk);

        // 1: single source, three-beat message, back-to-back writes
        do_reset();
        enable = 1'b1;
        push_msg(0, 3, 64'hA0, 1'b1);
        run(8);
        chk("t1_nwr", 64'(n_wr), 64'd3);
        chk("t1_gap", 64'(obs_cyc[2] - obs_cyc[0]), 64'd2);
        // STREAM spans the grant edge to the last-beat edge: three cycles
        chk("t1_busy", 64'(n_busy), 64'd3);
        chk("t1_sb", 64'(sb.size()), 64'd0);

        // 2: all sources, one-beat messages, round-robin with a bubble
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < NR; i++) push_msg(i, 1, 64'hB0 + 64'(i), 1'b1);
        push_msg(0, 1, 64'hB4, 1'b1);
        run(14);
        chk("t2_nwr", 64'(n_wr), 64'd5);
        chk("t2_o0", 64'(obs_src[0]), 64'd0);
        chk("t2_o1", 64'(obs_src[1]), 64'd1);
        chk("t2_o2", 64'(obs_src[2]), 64'd2);
        chk("t2_o3", 64'(obs_src[3]), 64'd3);
        chk("t2_o4", 64'(obs_src[4]), 64'd0);
        chk("t2_gap", 64'(obs_cyc[1] - obs_cyc[0]), 64'd2);

        // 3: 20 beats, no last -> cut at beat 16, re-grant, beats 17..20
        do_reset();
        enable = 1'b1;
        push_msg(2, 20, 64'hC00, 1'b0);
        run(30);
        chk("t3_nwr", 64'(n_wr), 64'd20);
        chk("t3_ntrunc", 64'(n_trunc), 64'd1);
        chk("t3_gap", 64'(obs_cyc[16] - obs_cyc[15]), 64'd2);
        chk("t3_sb", 64'(sb.size()), 64'd0);

        // 3b: last on beat 16 is a clean end
        do_reset();
        enable = 1'b1;
        push_msg(0, 16, 64'hD00, 1'b1);
        run(22);
        chk("t3b_nwr", 64'(n_wr), 64'd16);
        chk("t3b_ntrunc", 64'(n_trunc), 64'd0);

        // 4: src1 goes silent after one beat -> watchdog after 64 stall cycles
        do_reset();
        enable = 1'b1;
        push_msg(1, 1, 64'hE0, 1'b0);
        wait_wr(1, 10);
        k = 0;
        for (int n = 1; n <= 100; n++) begin
            cyc();
            if (n_tmo > 0) begin
                k = n;
                break;
            end
        end
        chk("t4_tmo_at", 64'(k), 64'(TO));
        chk("t4_busy", 64'(busy), 64'd0);
        cyc();
        chk("t4_pulse", 64'(n_tmo), 64'd1);
        cnt_m[1] = 0;
        for (int i = 0; i < 3; i++) push_msg(i, 1, 64'hE10 + 64'(i), 1'b1);
        run(10);
        // rr_ptr now 2: order 2, then 0, then 1
        chk("t4_nwr", 64'(n_wr), 64'd4);
        chk("t4_o1", 64'(obs_src[1]), 64'd2);
        chk("t4_o2", 64'(obs_src[2]), 64'd0);
        chk("t4_o3", 64'(obs_src[3]), 64'd1);

        // 5: backpressure mid-message is not a stall; enable drop does not abort
        do_reset();
        enable = 1'b1;
        push_msg(3, 6, 64'hF0, 1'b1);
        wait_wr(2, 10);
        memq_ready = 1'b0;
        enable     = 1'b0;
        run(100);
        chk("t5_frozen", 64'(n_wr), 64'd2);
        chk("t5_notmo", 64'(n_tmo), 64'd0);
        chk("t5_busy", 64'(busy), 64'd1);
        memq_ready = 1'b1;
        run(10);
        chk("t5_nwr", 64'(n_wr), 64'd6);
        chk("t5_sb", 64'(sb.size()), 64'd0);
        chk("t5_notmo2", 64'(n_tmo), 64'd0);

        // 6: reset mid-message clears immediately; enable=0 blocks new grants
        do_reset();
        enable = 1'b1;
        push_msg(0, 5, 64'h100, 1'b1);
        wait_wr(2, 10);
        rst = 1'b1;
        #1;
        chk("t6_write", 64'(memq_write), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_chunk", ipg_reply_chunk, 64'd0);
        chk("t6_ready", 64'(req_ready), 64'd0);
        flush();
        enable = 1'b0;
        push_msg(0, 3, 64'h200, 1'b1);
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(10);
        chk("t6_nogrant", 64'(n_busy), 64'd0);
        chk("t6_nowr", 64'(n_wr), 64'd0);
        enable = 1'b1;
        run(8);
        chk("t6_nwr", 64'(n_wr), 64'd3);
        chk("t6_sb", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
